// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: owns the PC, issues word reads to imem, buffers returned words in order.
// Latency: response to instValid 1 cycle (0 with IFQ_BYPASS_EN defined); redirect to new instValid 2 + mem latency.
// Backpressure: instReady low holds the head; issue stops once queued + outstanding words reach DEPTH.

// Generic in-order FIFO with synchronous clear.
// Latency: a pushed word reaches the head on the next cycle.
// Backpressure: none internal; the owner must not push when full (a push alongside a pop is always accepted).
module ifq_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_rdy,
  output logic                   head_vld,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign head_vld = (count != '0);
  assign head_dat = store[rd_ptr];
  assign do_pop   = pop_rdy & head_vld;
  assign do_push  = push_vld & ((count != (AW+1)'(DEPTH)) | do_pop);

  // Pointer and occupancy update; clear empties the queue without touching storage.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Entry storage; unreset because head_dat is only consumed while head_vld is high.
  always_ff @(posedge clk) begin
    if (do_push && !clr) store[wr_ptr] <= push_dat;
  end
endmodule

module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clockIF,
  input  logic        resetIF,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic        instValid,
  input  logic        instReady,
  output logic [31:0] instOut,
  output logic [31:0] pcOut,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_nxt;
  logic [31:0]   tail_pc;
  logic [31:0]   tail_pc_nxt;
  logic [31:0]   redirect_pc_aligned;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] out_after_resp;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_nxt;
  logic [CW-1:0] q_count;
  logic [CW:0]   in_use;
  logic          run;
  logic          credit_ok;
  logic          issue;
  logic          resp;
  logic          accept;
  logic          push;
  logic          pop;
  logic          q_head_vld;
  entry_t        q_head;
  entry_t        head;
  entry_t        push_entry;

  assign run                 = (state == RUN);
  assign redirect_pc_aligned = redirectPc & ~32'h3;

  // A response only counts when a request is actually in flight; strays are ignored.
  assign resp           = imemRvalid & (outstanding != '0);
  assign out_after_resp = outstanding - CW'(resp);
  // Responses in RUN outside a redirect cycle are real instructions; everything else is discarded.
  assign accept         = run & resp & ~redirectValid;
  assign push_entry     = '{pc: tail_pc, inst: imemRdata};

  // Queued words plus words in flight may never exceed the queue size, so every response has a slot.
  assign in_use    = {1'b0, q_count} + {1'b0, outstanding};
  assign credit_ok = (in_use < (CW+1)'(DEPTH));

  // Issue is suppressed in the redirect cycle so no request goes out at a wrong-path address.
  assign imemReq  = run & credit_ok & ~redirectValid & ~resetIF;
  assign imemAddr = resetIF ? RESET_PC : fetch_pc;
  assign issue    = imemReq & imemAck;

`ifdef IFQ_BYPASS_EN
  logic   bypass;
  entry_t bypass_entry;

  // Bypass only when nothing is queued: the queued head always has priority for the single output slot.
  assign bypass       = accept & (q_count == '0) & ~resetIF;
  assign bypass_entry = push_entry;
  assign instValid    = (q_head_vld | bypass) & ~resetIF;
  assign head         = q_head_vld ? q_head : bypass_entry;
  assign pop          = instValid & instReady;
  // A bypassed word that is consumed on the spot must not also land in the queue.
  assign push         = accept & ~(bypass & instReady);
`else
  assign instValid = q_head_vld & ~resetIF;
  assign head      = q_head;
  assign pop       = instValid & instReady;
  assign push      = accept;
`endif

  assign instOut = instValid ? head.inst : 32'h0;
  assign pcOut   = instValid ? head.pc   : 32'h0;

  ifq_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clockIF),
    .rst      (resetIF),
    .clr      (redirectValid),
    .push_vld (push),
    .push_dat (push_entry),
    .pop_rdy  (pop & q_head_vld),
    .head_vld (q_head_vld),
    .head_dat (q_head),
    .count    (q_count)
  );

  // Next-state, drain count and PC bookkeeping.
  always_comb begin
    state_nxt       = state;
    drop_nxt        = drop_cnt;
    fetch_pc_nxt    = fetch_pc;
    tail_pc_nxt     = tail_pc;
    outstanding_nxt = outstanding + CW'(issue) - CW'(resp);

    if (issue)  fetch_pc_nxt = fetch_pc + 32'd4;
    if (accept) tail_pc_nxt  = tail_pc + 32'd4;

    if (redirectValid) begin
      // Everything still in flight after this cycle's response belongs to the old path.
      drop_nxt     = out_after_resp;
      fetch_pc_nxt = redirect_pc_aligned;
      tail_pc_nxt  = redirect_pc_aligned;
    end else if (state == FLUSH) begin
      drop_nxt = drop_cnt - CW'(resp);
    end

    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (redirectValid && (drop_nxt != '0)) state_nxt = FLUSH;
      FLUSH:   if (drop_nxt == '0) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // State registers; reset overrides every other input.
  always_ff @(posedge clockIF) begin
    if (resetIF) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      tail_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      tail_pc     <= tail_pc_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_nxt;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: in-order memory model, queue-level reference model, directed scenarios.
// Every cycle the DUT outputs are compared with the reference model; scenario literals pin the model.
// Memory responds in issue order after a programmable latency.
module tb_instruction_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clockIF = 1'b0;
  logic        resetIF;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        instValid;
  logic        instReady;
  logic [31:0] instOut;
  logic [31:0] pcOut;
  logic        redirectValid;
  logic [31:0] redirectPc;

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clockIF       (clockIF),
    .resetIF       (resetIF),
    .imemReq       (imemReq),
    .imemAddr      (imemAddr),
    .imemAck       (imemAck),
    .imemRvalid    (imemRvalid),
    .imemRdata     (imemRdata),
    .instValid     (instValid),
    .instReady     (instReady),
    .instOut       (instOut),
    .pcOut         (pcOut),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc)
  );

  always #5 clockIF = ~clockIF;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mem_lat  = 1;

  // Memory: requests accepted but not yet answered.
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  // Reference model: words in flight (address + wrong-path flag), visible queue, fetch PC, mode.
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } fl_t;
  fl_t         inflight[$];
  logic [63:0] mq[$];
  logic [31:0] m_pc = RESET_PC;
  int          m_mode = 0; // 0 idle, 1 run, 2 flush

  // Observations for scenario literals.
  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] issue_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] pop_inst[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic clear_logs();
    issue_log.delete();
    pop_log.delete();
    pop_inst.delete();
  endtask

  // One clock cycle: memory drives its response, outputs are checked at the falling edge, model advances.
  task automatic step();
    fl_t         f;
    bit          e_req;
    bit          e_val;
    bit          byp;
    bit          popped_byp;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    imemRvalid = 1'b0;
    imemRdata  = 32'h0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imemRvalid = 1'b1;
      imemRdata  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    @(negedge clockIF);
    byp = 1'b0;
    if (resetIF) begin
      e_req = 1'b0; e_addr = RESET_PC; e_val = 1'b0; e_inst = 32'h0; e_pc = 32'h0;
    end else begin
      e_req  = (m_mode == 1) && !redirectValid && (mq.size() + inflight.size() < DEPTH);
      e_addr = m_pc;
`ifdef IFQ_BYPASS_EN
      byp = (m_mode == 1) && imemRvalid && (inflight.size() > 0) && !redirectValid && (mq.size() == 0);
`endif
      e_val  = (mq.size() > 0) || byp;
      e_inst = 32'h0;
      e_pc   = 32'h0;
      if (mq.size() > 0) begin
        e_pc   = mq[0][63:32];
        e_inst = mq[0][31:0];
      end else if (byp) begin
        e_pc   = inflight[0].addr;
        e_inst = imemRdata;
      end
    end
    check("imemReq", {31'h0, imemReq}, {31'h0, e_req});
    check("imemAddr", imemAddr, e_addr);
    check("instValid", {31'h0, instValid}, {31'h0, e_val});
    if (e_val || resetIF) begin
      check("pcOut", pcOut, e_pc);
      check("instOut", instOut, e_inst);
    end
    s_req   = imemReq;
    s_valid = instValid;
    s_addr  = imemAddr;
    if (imemReq && imemAck) begin
      issue_log.push_back(imemAddr);
      pend_addr.push_back(imemAddr);
      pend_due.push_back(cyc + mem_lat);
    end
    if (instValid && instReady) begin
      pop_log.push_back(pcOut);
      pop_inst.push_back(instOut);
    end
    if (resetIF) begin
      mq.delete();
      inflight.delete();
      m_pc   = RESET_PC;
      m_mode = 0;
    end else begin
      popped_byp = 1'b0;
      if (e_val && instReady) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else popped_byp = 1'b1;
      end
      if (imemRvalid && inflight.size() > 0) begin
        f = inflight.pop_front();
        if (!f.stale && m_mode == 1 && !redirectValid && !popped_byp)
          mq.push_back({f.addr, imemRdata});
      end
      if (e_req && imemAck) begin
        inflight.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (redirectValid) begin
        mq.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        m_pc   = redirectPc & ~32'h3;
        m_mode = (inflight.size() > 0) ? 2 : 1;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 2 && inflight.size() == 0) begin
        m_mode = 1;
      end
    end
    @(posedge clockIF);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    resetIF       = 1'b1;
    redirectValid = 1'b0;
    instReady     = 1'b0;
    imemAck       = 1'b0;
    repeat (n) step();
    resetIF = 1'b0;
  endtask

  initial begin
    int idx;
    int n;
    logic [31:0] exp_byp_valid;
    resetIF = 1'b1; instReady = 1'b0; imemAck = 1'b0; redirectValid = 1'b0;
    redirectPc = 32'h0; imemRvalid = 1'b0; imemRdata = 32'h0;
    @(posedge clockIF);
    #1;

    // Straight-line fetch with single-cycle memory and a always-ready consumer.
    mem_lat = 1;
    do_reset(2);
    check("rst_req", {31'h0, s_req}, 32'h0);
    check("rst_valid", {31'h0, s_valid}, 32'h0);
    check("rst_addr", s_addr, 32'h0);
    clear_logs();
    instReady = 1'b1; imemAck = 1'b1;
    repeat (12) step();
    check("seq_issue0", at(issue_log, 0), 32'h0);
    check("seq_issue1", at(issue_log, 1), 32'h4);
    check("seq_issue2", at(issue_log, 2), 32'h8);
    check("seq_pc0", at(pop_log, 0), 32'h0);
    check("seq_pc1", at(pop_log, 1), 32'h4);
    check("seq_pc2", at(pop_log, 2), 32'h8);
    check("seq_inst0", at(pop_inst, 0), 32'h1357_9BDF);

    // Consumer stalled: credits cap the issues at DEPTH, then drain in order and resume.
    do_reset(2);
    clear_logs();
    instReady = 1'b0; imemAck = 1'b1;
    repeat (12) step();
    check("stall_issues", issue_log.size(), 32'd4);
    check("stall_req_off", {31'h0, s_req}, 32'h0);
    check("stall_valid", {31'h0, s_valid}, 32'h1);
    instReady = 1'b1;
    repeat (8) step();
    check("drain_pc0", at(pop_log, 0), 32'h0);
    check("drain_pc1", at(pop_log, 1), 32'h4);
    check("drain_pc2", at(pop_log, 2), 32'h8);
    check("drain_pc3", at(pop_log, 3), 32'hC);
    check("resume_issue", at(issue_log, 4), 32'h10);

    // Redirect with two requests outstanding: flush drops both, refetch at the aligned target.
    mem_lat = 4;
    do_reset(2);
    clear_logs();
    instReady = 1'b1; imemAck = 1'b1;
    repeat (3) step();
    imemAck = 1'b0; redirectValid = 1'b1; redirectPc = 32'h103;
    step();
    redirectValid = 1'b0; imemAck = 1'b1;
    n = 0;
    repeat (3) begin
      step();
      if (s_req || s_valid) n++;
    end
    check("flush_quiet", n, 32'd0);
    for (int i = 0; i < 40 && pop_log.size() == 0; i++) step();
    check("redir_issue", at(issue_log, 2), 32'h100);
    check("redir_pc", at(pop_log, 0), 32'h100);
    check("redir_inst", at(pop_inst, 0), 32'h1357_9ADF);

    // Redirect in the same cycle as a pop and a response.
    mem_lat = 1;
    do_reset(2);
    clear_logs();
    instReady = 1'b1; imemAck = 1'b1;
    repeat (6) step();
    redirectValid = 1'b1; redirectPc = 32'h200;
    step();
    redirectValid = 1'b0;
    idx = pop_log.size();
    check("same_cyc_pop", at(pop_log, idx - 1), 32'hC);
    for (int i = 0; i < 20 && pop_log.size() <= idx; i++) step();
    check("same_cyc_next", at(pop_log, idx), 32'h200);
    n = 0;
    foreach (pop_log[i]) if (pop_log[i] == 32'h10 || pop_log[i] == 32'hC) n++;
    check("same_cyc_once", n, 32'd1);

    // PC wrap at the top of the address space.
    do_reset(2);
    clear_logs();
    instReady = 1'b1; imemAck = 1'b1;
    step();
    redirectValid = 1'b1; redirectPc = 32'hFFFF_FFFC;
    step();
    redirectValid = 1'b0;
    repeat (6) step();
    check("wrap_issue0", at(issue_log, 0), 32'hFFFF_FFFC);
    check("wrap_issue1", at(issue_log, 1), 32'h0);
    check("wrap_pc0", at(pop_log, 0), 32'hFFFF_FFFC);
    check("wrap_pc1", at(pop_log, 1), 32'h0);
    check("wrap_inst0", at(pop_inst, 0), 32'hECA8_6423);

    // Reset in the middle of a flush; late responses must be ignored.
    mem_lat = 5;
    do_reset(2);
    clear_logs();
    instReady = 1'b1; imemAck = 1'b1;
    repeat (3) step();
    imemAck = 1'b0; redirectValid = 1'b1; redirectPc = 32'h40;
    step();
    redirectValid = 1'b0; imemAck = 1'b1;
    step();
    resetIF = 1'b1; imemAck = 1'b0;
    step();
    resetIF = 1'b0;
    clear_logs();
    step();
    check("midrst_valid", {31'h0, s_valid}, 32'h0);
    check("midrst_req", {31'h0, s_req}, 32'h0);
    check("midrst_addr", s_addr, 32'h0);
    for (int i = 0; i < 20 && pend_addr.size() > 0; i++) step();
    check("midrst_nopop", pop_log.size(), 32'd0);
    imemAck = 1'b1;
    for (int i = 0; i < 30 && pop_log.size() == 0; i++) step();
    check("midrst_pc", at(pop_log, 0), 32'h0);
    check("midrst_inst", at(pop_inst, 0), 32'h1357_9BDF);

    // Response-to-instValid latency on an empty queue.
`ifdef IFQ_BYPASS_EN
    exp_byp_valid = 32'h1;
`else
    exp_byp_valid = 32'h0;
`endif
    mem_lat = 1;
    do_reset(2);
    instReady = 1'b0; imemAck = 1'b1;
    repeat (3) step();
    check("resp_cycle_valid", {31'h0, s_valid}, exp_byp_valid);
    step();
    check("resp_next_valid", {31'h0, s_valid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d expected run to finish", cyc);
    $fatal(1);
  end
endmodule
